// File: rtl/t01_drop_timer.sv
// ---------------------------------------------------------------------------
// t01_drop_timer
//
// Gravity tick generator. It turns the speed controller's scoremod into
// piece-drop requests for the game FSM. The drop period is
// BASE_PERIOD - scoremod, floored at MIN_PERIOD, so the game speeds up as the
// score rises. A tick is raised on drop_tick and held until drop_ack.
//
// Optional feature: define T01_SOFTDROP_EN to enable the soft-drop period.
// While soft_drop is held in RUN, the period is capped at SOFT_PERIOD. Without
// the macro, soft_drop is ignored and SOFT_PERIOD is unused.
//
// Ports
//   clk          in   1   system clock
//   reset        in   1   synchronous active-low reset
//   enable       in   1   game running; 0 returns to IDLE and clears the tick
//   pause        in   1   freeze counting while keeping state
//   soft_drop    in   1   player holding down (T01_SOFTDROP_EN only)
//   scoremod     in   25  period reduction from the speed controller
//   drop_ack     in   1   game FSM has taken the pending tick
//   drop_tick    out  1   tick pending (level, held until acknowledged)
//   tick_overrun out  1   sticky: a tick expired while the previous one was pending
//   cur_period   out  25  period currently in use
//   timer_state  out  2   00 IDLE, 01 RUN, 10 PAUSE
// ---------------------------------------------------------------------------
module t01_drop_timer #(
    parameter int BASE_PERIOD = 25_000_000,
    parameter int MIN_PERIOD  = 5_000_000,
    parameter int SOFT_PERIOD = 2_500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pause,
    input  logic        soft_drop,
    input  logic [24:0] scoremod,
    input  logic        drop_ack,
    output logic        drop_tick,
    output logic        tick_overrun,
    output logic [24:0] cur_period,
    output logic [1:0]  timer_state
);

    localparam logic [24:0] BASE_P  = 25'(BASE_PERIOD);
    localparam logic [24:0] MIN_P   = 25'(MIN_PERIOD);
    localparam logic [24:0] RANGE_P = 25'(BASE_PERIOD - MIN_PERIOD);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t      state_reg;
    logic [24:0] count_reg;
    logic [24:0] period_reg;
    logic        drop_tick_reg;
    logic        overrun_reg;

    logic [24:0] period_calc;
    logic [24:0] eff_period;
    logic        at_end;
    logic        fire;

    // Compare before subtracting so scoremod can never underflow the period.
    always_comb begin
        period_calc = BASE_P - scoremod;
        if (scoremod >= RANGE_P) begin
            period_calc = MIN_P;
        end
    end

`ifdef T01_SOFTDROP_EN
    localparam logic [24:0] SOFT_P = 25'(SOFT_PERIOD);

    // Soft drop only shortens the period; a shorter normal period still wins.
    always_comb begin
        eff_period = period_reg;
        if (soft_drop && (period_reg > SOFT_P)) begin
            eff_period = SOFT_P;
        end
    end
`else
    logic unused_soft_drop;
    assign unused_soft_drop = soft_drop;
    assign eff_period       = period_reg;
`endif

    // ">=" rather than "==" so that a count already past the shortened soft
    // period fires immediately when soft_drop rises.
    assign at_end = (count_reg >= (eff_period - 25'd1));

    // A RUN or PAUSE cycle with pause low is an active counting cycle. This
    // makes the release cycle of a pause count, so a pause of N cycles delays
    // the next tick by exactly N cycles.
    assign fire = enable && (state_reg != IDLE) && !pause && at_end;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            period_reg    <= BASE_P;
            drop_tick_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else if (!enable) begin
            // enable has priority over pause and over any pending tick
            state_reg     <= IDLE;
            count_reg     <= '0;
            drop_tick_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg  <= RUN;
                    count_reg  <= '0;
                    period_reg <= period_calc;
                end
                default: begin
                    if (pause) begin
                        state_reg <= PAUSE;
                    end else begin
                        state_reg <= RUN;
                        if (at_end) begin
                            count_reg  <= '0;
                            period_reg <= period_calc;
                        end else begin
                            count_reg <= count_reg + 25'd1;
                        end
                    end
                end
            endcase

            // Tick handshake. A fire keeps the tick raised; it is an overrun
            // only if the previous tick was pending and not taken this cycle.
            if (fire) begin
                drop_tick_reg <= 1'b1;
                if (drop_tick_reg && !drop_ack) begin
                    overrun_reg <= 1'b1;
                end
            end else if (drop_ack) begin
                drop_tick_reg <= 1'b0;
            end
        end
    end

    assign drop_tick    = drop_tick_reg;
    assign tick_overrun = overrun_reg;
    assign cur_period   = period_reg;
    assign timer_state  = state_reg;

endmodule
